// File: rtl/text_lcd_pkg.sv
// Shared types and HD44780 command constants for the text LCD buffer controller.
package text_lcd_pkg;

  typedef enum logic [3:0] {
    S_POWER_WAIT,
    S_FUNC_SET,
    S_DISP_ON,
    S_ENTRY,
    S_CLEAR,
    S_CLEAR_WAIT,
    S_SET_ADDR,
    S_WRITE_CHAR,
    S_IDLE
  } lcd_state_e;

  localparam logic [7:0] CMD_FUNC_8B_2L = 8'h38;
  localparam logic [7:0] CMD_FUNC_8B_1L = 8'h30;
  localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_INC  = 8'h06;
  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_SET_DDRAM  = 8'h80;
  localparam logic [7:0] CHAR_SPACE     = 8'h20;

  // DDRAM start address of a display line; lines 2/3 continue rows 0/1.
  function automatic logic [6:0] line_base(input logic [1:0] line, input int unsigned cols);
    logic [6:0] base;
    case (line)
      2'd0:    base = 7'h00;
      2'd1:    base = 7'h40;
      2'd2:    base = 7'(cols);
      default: base = 7'(32'h40 + cols);
    endcase
    return base;
  endfunction

endpackage

// File: rtl/text_lcd_buf_ctrl_step_timer.sv
// Per-transaction step counter: paces the LCD bus and shapes the LCD_E strobe.
module lcd_step_timer #(
  parameter int unsigned STEP_CYCLES = 20
) (
  input  logic clk,
  input  logic resetn,
  input  logic run_i,
  output logic step_start_o,
  output logic step_end_o,
  output logic lcd_e_o
);

  localparam int unsigned SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic          e_q, e_d;

  always_comb begin
    step_cnt_d = '0;
    if (run_i && (32'(step_cnt_q) != STEP_CYCLES - 1))
      step_cnt_d = step_cnt_q + 1'b1;
    // Strobe registered from the next count so it is high exactly for counts 1..STEP_CYCLES/2.
    e_d = (step_cnt_d != '0) && (32'(step_cnt_d) <= STEP_CYCLES / 2);
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      step_cnt_q <= '0;
      e_q        <= 1'b0;
    end else begin
      step_cnt_q <= step_cnt_d;
      e_q        <= e_d;
    end
  end

  assign step_start_o = run_i && (step_cnt_q == '0);
  assign step_end_o   = run_i && (32'(step_cnt_q) == STEP_CYCLES - 1);
  assign lcd_e_o      = e_q;

endmodule

// File: rtl/text_lcd_buf_ctrl.sv
// HD44780 8-bit controller repainting the panel from a LINES x COLS character buffer.
// Optional: define TEXT_LCD_DIRTY_REFRESH_EN to repaint only after buffer writes.
module text_lcd_buf_ctrl
  import text_lcd_pkg::*;
#(
  parameter int unsigned COLS         = 16,
  parameter int unsigned LINES        = 2,
  parameter int unsigned STEP_CYCLES  = 20,
  parameter int unsigned INIT_WAIT    = 70,
  parameter int unsigned CLEAR_WAIT   = 200,
  parameter int unsigned REFRESH_WAIT = 400
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       wr_en,
  input  logic [1:0] wr_line,
  input  logic [4:0] wr_col,
  input  logic [7:0] wr_char,
  output logic       busy,
  output logic       refresh_done,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA
);

  localparam int unsigned MAX_WAIT =
    (INIT_WAIT > CLEAR_WAIT) ? ((INIT_WAIT > REFRESH_WAIT) ? INIT_WAIT : REFRESH_WAIT)
                             : ((CLEAR_WAIT > REFRESH_WAIT) ? CLEAR_WAIT : REFRESH_WAIT);
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam int unsigned LW = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

  lcd_state_e    state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [LW-1:0] line_q, line_d;
  logic [CW-1:0] col_q, col_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          refresh_done_q, refresh_done_d;
  logic [7:0]    buf_mem_q [LINES][COLS];

  logic          wr_accept, bus_state, step_start, step_end, refresh_go;
  logic          bus_rs;
  logic [7:0]    bus_data;

  assign wr_accept = wr_en && (32'(wr_line) < LINES) && (32'(wr_col) < COLS);
  assign bus_state = state_q inside {S_FUNC_SET, S_DISP_ON, S_ENTRY, S_CLEAR,
                                     S_SET_ADDR, S_WRITE_CHAR};

  lcd_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_step_timer (
    .clk          (clk),
    .resetn       (resetn),
    .run_i        (bus_state),
    .step_start_o (step_start),
    .step_end_o   (step_end),
    .lcd_e_o      (LCD_E)
  );

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      for (int unsigned l = 0; l < LINES; l++)
        for (int unsigned c = 0; c < COLS; c++)
          buf_mem_q[LW'(l)][CW'(c)] <= CHAR_SPACE;
    end else if (wr_accept) begin
      buf_mem_q[LW'(wr_line)][CW'(wr_col)] <= wr_char;
    end
  end

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    line_d         = line_q;
    col_d          = col_q;
    refresh_done_d = 1'b0;
    bus_rs         = 1'b0;
    bus_data       = '0;
    case (state_q)
      S_POWER_WAIT: begin
        if (32'(wait_q) == INIT_WAIT - 1) begin
          state_d = S_FUNC_SET;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_FUNC_SET: begin
        bus_data = (LINES == 1) ? CMD_FUNC_8B_1L : CMD_FUNC_8B_2L;
        if (step_end) state_d = S_DISP_ON;
      end
      S_DISP_ON: begin
        bus_data = CMD_DISP_ON;
        if (step_end) state_d = S_ENTRY;
      end
      S_ENTRY: begin
        bus_data = CMD_ENTRY_INC;
        if (step_end) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        bus_data = CMD_CLEAR;
        if (step_end) state_d = S_CLEAR_WAIT;
      end
      S_CLEAR_WAIT: begin
        if (32'(wait_q) == CLEAR_WAIT - 1) begin
          state_d = S_SET_ADDR;
          wait_d  = '0;
          line_d  = '0;
          col_d   = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_SET_ADDR: begin
        bus_data = CMD_SET_DDRAM | {1'b0, line_base(2'(line_q), COLS)};
        if (step_end) begin
          state_d = S_WRITE_CHAR;
          col_d   = '0;
        end
      end
      S_WRITE_CHAR: begin
        bus_rs   = 1'b1;
        bus_data = buf_mem_q[line_q][col_q];
        if (step_end) begin
          if (32'(col_q) == COLS - 1) begin
            col_d = '0;
            if (32'(line_q) == LINES - 1) begin
              state_d        = S_IDLE;
              line_d         = '0;
              refresh_done_d = 1'b1;
            end else begin
              state_d = S_SET_ADDR;
              line_d  = line_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_IDLE: begin
        // Counter parks at its terminal value until a repaint is allowed.
        if (32'(wait_q) == REFRESH_WAIT - 1) begin
          if (refresh_go) begin
            state_d = S_SET_ADDR;
            wait_d  = '0;
            line_d  = '0;
            col_d   = '0;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = S_POWER_WAIT;
    endcase
    rs_d   = step_start ? bus_rs : rs_q;
    data_d = step_start ? bus_data : data_q;
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q        <= S_POWER_WAIT;
      wait_q         <= '0;
      line_q         <= '0;
      col_q          <= '0;
      rs_q           <= 1'b0;
      data_q         <= '0;
      refresh_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      line_q         <= line_d;
      col_q          <= col_d;
      rs_q           <= rs_d;
      data_q         <= data_d;
      refresh_done_q <= refresh_done_d;
    end
  end

`ifdef TEXT_LCD_DIRTY_REFRESH_EN
  logic dirty_q, dirty_d, pass_start;

  assign pass_start = (state_q inside {S_IDLE, S_CLEAR_WAIT}) && (state_d == S_SET_ADDR);

  always_comb begin
    dirty_d = dirty_q;
    if (pass_start) dirty_d = 1'b0;
    if (wr_accept)  dirty_d = 1'b1;
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) dirty_q <= 1'b0;
    else        dirty_q <= dirty_d;
  end

  assign refresh_go = dirty_q;
`else
  assign refresh_go = 1'b1;
`endif

  assign busy         = (state_q != S_IDLE);
  assign refresh_done = refresh_done_q;
  assign LCD_RS       = rs_q;
  assign LCD_RW       = 1'b0;
  assign LCD_DATA     = data_q;

endmodule

// File: tb/tb_text_lcd_buf_ctrl.sv
// Scoreboard bench for text_lcd_buf_ctrl: expected bus transactions are queued, a monitor checks each LCD_E strobe.
`timescale 1ns/1ps
module tb_text_lcd_buf_ctrl;

  localparam int unsigned COLS = 4, LINES = 2, STEP = 4, INITW = 10, CLRW = 8, REFW = 20;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_line = '0;
  logic [4:0] wr_col = '0;
  logic [7:0] wr_char = '0;
  logic       busy, refresh_done, LCD_E, LCD_RS, LCD_RW;
  logic [7:0] LCD_DATA;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [8:0] exp_q[$];

  logic       prev_e = 1'b0;
  int         hi_len = 0;
  logic [8:0] cap_bus = '0;

  always #5 clk = ~clk;

  text_lcd_buf_ctrl #(
    .COLS(COLS), .LINES(LINES), .STEP_CYCLES(STEP),
    .INIT_WAIT(INITW), .CLEAR_WAIT(CLRW), .REFRESH_WAIT(REFW)
  ) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_line(wr_line), .wr_col(wr_col),
    .wr_char(wr_char), .busy(busy), .refresh_done(refresh_done), .LCD_E(LCD_E),
    .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  // Monitor: every rising LCD_E pops one expected {RS,DATA}; strobe width and bus hold checked on the fall.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn) begin
        prev_e = 1'b0;
        hi_len = 0;
      end else begin
        if (refresh_done) done_cnt++;
        if (LCD_E && !prev_e) begin
          cap_bus = {LCD_RS, LCD_DATA};
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got 0x%0h expected no transaction", cap_bus);
          end else begin
            check("bus", 32'(cap_bus), 32'(exp_q.pop_front()));
          end
        end
        if (LCD_E) begin
          hi_len++;
        end else if (prev_e) begin
          check("e_width", hi_len, 2);
          check("bus_hold", {23'b0, LCD_RS, LCD_DATA}, 32'(cap_bus));
          hi_len = 0;
        end
        prev_e = LCD_E;
      end
    end
  end

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h01});
  endtask

  // l0/l1 hold the four characters of each line, column 0 in the top byte.
  task automatic push_pass(input logic [31:0] l0, input logic [31:0] l1);
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 3; i >= 0; i--) exp_q.push_back({1'b1, l0[i*8 +: 8]});
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 3; i >= 0; i--) exp_q.push_back({1'b1, l1[i*8 +: 8]});
  endtask

  task automatic do_write(input int l, input int c, input logic [7:0] ch);
    @(negedge clk);
    wr_en = 1'b1; wr_line = 2'(l); wr_col = 5'(c); wr_char = ch;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!refresh_done && n < 1000);
    if (!refresh_done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no refresh_done expected pulse within 1000 clocks", name);
    end else begin
      check({name, "_busy"}, 32'(busy), 0);
      check({name, "_queue"}, exp_q.size(), 0);
      @(negedge clk);
      check({name, "_pulse_len"}, 32'(refresh_done), 0);
    end
  endtask

  task automatic release_and_check_power_wait();
    @(negedge clk);
    resetn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("power_wait", {20'b0, busy, LCD_E, LCD_RS, LCD_RW, LCD_DATA}, 32'h800);
    end
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_e"}, 32'(LCD_E), 0);
    check({name, "_rs"}, 32'(LCD_RS), 0);
    check({name, "_rw"}, 32'(LCD_RW), 0);
    check({name, "_data"}, 32'(LCD_DATA), 0);
    check({name, "_busy"}, 32'(busy), 1);
    check({name, "_done"}, 32'(refresh_done), 0);
  endtask

`ifdef TEXT_LCD_DIRTY_REFRESH_EN
  task automatic quiet(input string name, input int cycles);
    int d0 = done_cnt;
    repeat (cycles) @(negedge clk);
    check(name, done_cnt - d0, 0);
  endtask
`endif

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset_values("reset");

    push_init();
    push_pass(32'h20202020, 32'h20202020);
    release_and_check_power_wait();
    wait_done("init_pass");

    do_write(1, 2, 8'h41);
    push_pass(32'h20202020, 32'h20204120);
    wait_done("write_pass");

    do_write(2, 1, 8'h5A);
    do_write(0, 4, 8'h59);
`ifdef TEXT_LCD_DIRTY_REFRESH_EN
    quiet("no_write_no_pass", 3 * REFW + 10);
    do_write(1, 1, 8'h20);
`endif
    push_pass(32'h20202020, 32'h20204120);
    wait_done("oor_pass");
`ifdef TEXT_LCD_DIRTY_REFRESH_EN
    quiet("one_write_one_pass", 2 * REFW + 10);
    do_write(1, 1, 8'h20);
`endif

    exp_q.push_back({1'b0, 8'h80});
    repeat (3) exp_q.push_back({1'b1, 8'h20});
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    check("pre_reset_e_high", 32'(LCD_E), 1);
    #1 resetn = 1'b1;
    #1 check_reset_values("mid_reset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    push_init();
    push_pass(32'h20202020, 32'h20202020);
    release_and_check_power_wait();
    wait_done("reinit_pass");

`ifdef TEXT_LCD_DIRTY_REFRESH_EN
    do_write(1, 1, 8'h20);
`endif
    push_pass(32'h20202020, 32'h20202042);
    n = 0;
    while (exp_q.size() > 8 && n < 1000) begin @(negedge clk); n++; end
    do_write(1, 3, 8'h42);
    do_write(0, 0, 8'h43);
    wait_done("midpass_a");
    push_pass(32'h43202020, 32'h20202042);
    wait_done("midpass_b");
`ifdef TEXT_LCD_DIRTY_REFRESH_EN
    quiet("two_passes_only", 3 * REFW + 10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected finish before 500us");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule

// File: doc/text_lcd_buf_ctrl.md
Name: text_lcd_buf_ctrl

Overview:
- Parametrised HD44780-compatible 8-bit character-LCD controller with an internal character buffer of LINES x COLS.
- The host writes characters through a simple write port. The block runs the power-up init sequence, then continuously re-paints the panel from the buffer.
- It drives LCD_E as a timed strobe, not a copy of clk. It sits between game or status logic and the board's text-LCD pins.

Parameters:
- COLS, 16, characters per line (1..20).
- LINES, 2, display lines (1, 2 or 4).
- STEP_CYCLES, 20, clocks per LCD bus transaction (>=4).
- INIT_WAIT, 70, clocks idle after reset before the first command.
- CLEAR_WAIT, 200, extra clocks after the clear command.
- REFRESH_WAIT, 400, clocks idle between repaint passes.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous reset, active-high (resetn, asynchronous, active-high; clock clk).
- wr_en  in  1  host write strobe, one character per cycle.
- wr_line  in  2  target line.
- wr_col  in  5  target column.
- wr_char  in  8  ASCII code.
- busy  out  1  high while init or a repaint pass is in progress.
- refresh_done  out  1  one-cycle pulse at the end of each full repaint pass.
- LCD_E  out  1  enable strobe.
- LCD_RS  out  1  0 = command, 1 = data.
- LCD_RW  out  1  always 0 after reset (write-only).
- LCD_DATA  out  8  bus data.

Behaviour:
- Reset values:
  - LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00.
  - busy=1, refresh_done=0.
  - All buffer cells = 0x20 (space).
  - State = POWER_WAIT, counters = 0.
- Reset asserted mid-operation aborts immediately to these values.
- Step timing: each transaction lasts exactly STEP_CYCLES clocks, step_cnt 0..STEP_CYCLES-1.
  - RS and DATA are registered at step_cnt 0 and held stable for the whole step.
  - LCD_E=1 for step_cnt 1..STEP_CYCLES/2 (integer division), 0 otherwise.
- States and transitions:
  - POWER_WAIT: wait INIT_WAIT clocks.
  - FUNC_SET: cmd 0x38, or 0x30 when LINES==1.
  - DISP_ON: cmd 0x0C.
  - ENTRY: cmd 0x06.
  - CLEAR: cmd 0x01, then wait CLEAR_WAIT clocks.
  - SET_ADDR: cmd 0x80 | base(line).
  - WRITE_CHAR: COLS data steps, RS=1, DATA=buf[line][col].
  - After the last column: line+1 → SET_ADDR. After the last line → IDLE.
  - IDLE: wait REFRESH_WAIT clocks, then SET_ADDR with line 0. No CLEAR on repaints, to avoid flicker.
- Line base addresses: line0 0x00, line1 0x40, line2 COLS, line3 0x40+COLS.
- busy:
  - High from reset until IDLE is entered.
  - High again from leaving IDLE until the next IDLE.
  - refresh_done pulses on the clock that enters IDLE.
- Host writes:
  - Applied on the same clock edge, in every state including init.
  - wr_line>=LINES or wr_col>=COLS: write ignored.
  - A write to a cell already sent in the current pass appears on the next pass.
  - A write to a cell not yet sent appears in the current pass. The buffer read happens at step_cnt 0 of that cell's step.
- Counter widths: sized with $clog2 of the largest wait. No wrap is possible because every counter is cleared on its terminal count.

Optional Feature:
- Macro: TEXT_LCD_DIRTY_REFRESH_EN.
- Defined:
  - A dirty flag is set by any accepted write.
  - IDLE leaves only when dirty==1 and REFRESH_WAIT has elapsed.
  - The flag is cleared at the start of the pass, at SET_ADDR line 0. A write during a pass sets it again, forcing another pass.
  - The first pass after init always runs.
- Undefined: repaint is unconditional every REFRESH_WAIT clocks.

Decomposition:
- Package text_lcd_pkg:
  - State enum.
  - Command constants: CMD_FUNC_8B_2L=0x38, CMD_FUNC_8B_1L=0x30, CMD_DISP_ON=0x0C, CMD_ENTRY_INC=0x06, CMD_CLEAR=0x01, CMD_SET_DDRAM=0x80.
  - CHAR_SPACE=0x20.
  - Function line_base(line, cols).
- Sub-module lcd_step_timer: owns step_cnt, generates LCD_E, and outputs step_start/step_end pulses to the main FSM.

Test Plan (COLS=4, LINES=2, STEP_CYCLES=4, INIT_WAIT=10, CLEAR_WAIT=8, REFRESH_WAIT=20):
- Reset release:
  - Outputs hold reset values for 10 clocks.
  - Then the bus carries RS=0 DATA 0x38, 0x0C, 0x06, 0x01, each with a 4-clock step.
  - LCD_E is high for step_cnt 1..2 in each step.
- Init repaint:
  - 0x80, then 0x20 x4, then 0xC0, then 0x20 x4 (RS=1 on data).
  - refresh_done pulses once and busy falls on the same clock.
- Write line1 col2 = 0x41 while in IDLE:
  - The next pass shows the 3rd data byte after 0xC0 = 0x41.
  - No 0x01 is issued on this pass.
- Out-of-range write (wr_line=2, wr_col=1), then (wr_line=0, wr_col=4):
  - Buffer is unchanged and the next pass is identical to the previous one.
- Reset asserted during the WRITE_CHAR of line 0:
  - LCD_E drops to 0 on the same cycle.
  - After release, the full init sequence restarts from POWER_WAIT.
- With TEXT_LCD_DIRTY_REFRESH_EN:
  - No writes for 3 x REFRESH_WAIT → no pass after the first.
  - One write → exactly one pass follows.
  - A write mid-pass → two consecutive passes.
